// File: rtl/interp_pkg.sv
// Shared definitions for the span issuer and its integration into interp_pipe.
package interp_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_FRAC  = 16;
   localparam int DEF_LEN_W = 8;
   localparam int DEF_X_W   = 12;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef struct packed {
      logic [DEF_X_W-1:0]   x0;
      logic [DEF_LEN_W-1:0] len;
      logic [DEF_WIDTH-1:0] v0;
      logic [DEF_WIDTH-1:0] q0;
      logic [DEF_WIDTH-1:0] dv;
      logic [DEF_WIDTH-1:0] dq;
   } span_desc_t;

endpackage

// File: rtl/interp_accum.sv
// Pair of load/step accumulators holding the current v and 1/w values.
module interp_accum #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] init_v,
   input  logic [WIDTH-1:0] init_q,
   input  logic [WIDTH-1:0] dv,
   input  logic [WIDTH-1:0] dq,
   output logic [WIDTH-1:0] v,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] v_q;
   logic [WIDTH-1:0] q_q;

   // Load the span start values, or advance by one pixel's gradient with modulo wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q <= '0;
         q_q <= '0;
      end else if (load) begin
         v_q <= init_v;
         q_q <= init_q;
      end else if (step) begin
         v_q <= v_q + dv;
         q_q <= q_q + dq;
      end
   end

   assign v = v_q;
   assign q = q_q;

endmodule

// File: rtl/interp_span_issuer.sv
// Walks one span descriptor into a stream of per-pixel interpolator beats.
module interp_span_issuer
   import interp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int FRAC  = DEF_FRAC,
   parameter int LEN_W = DEF_LEN_W,
   parameter int X_W   = DEF_X_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             span_valid,
   output logic             span_ready,
   input  logic [X_W-1:0]   span_x0,
   input  logic [LEN_W-1:0] span_len,
   input  logic [WIDTH-1:0] span_v0,
   input  logic [WIDTH-1:0] span_q0,
   input  logic [WIDTH-1:0] span_dv,
   input  logic [WIDTH-1:0] span_dq,
   input  logic             abort,
   output logic             req_valid,
   input  logic             req_ready,
   output logic [X_W-1:0]   req_x,
   output logic [WIDTH-1:0] req_v,
   output logic [WIDTH-1:0] req_q,
   output logic [WIDTH-1:0] req_dv,
   output logic [WIDTH-1:0] req_dq,
   output logic             req_last,
   output logic             span_done,
   output logic             busy
);

   // Fractional bits never enter the integer arithmetic, but a nonsensical split is a setup error.
   if (FRAC > WIDTH) begin : g_frac_check
      $error("interp_span_issuer: FRAC exceeds WIDTH");
   end

   state_e           state_q;
   logic [LEN_W-1:0] remaining_q;
   logic [X_W-1:0]   x_q;
   logic [WIDTH-1:0] dv_q;
   logic [WIDTH-1:0] dq_q;
   logic             req_valid_q;
   logic             req_last_q;
   logic             span_done_q;

   logic accept;
   logic handshake;
   logic accum_load;
   logic accum_step;

   assign span_ready = (state_q == IDLE) && !abort;
   assign accept     = span_valid && span_ready;
   assign handshake  = req_valid_q && req_ready;
   assign accum_load = accept && (span_len != '0);
   assign accum_step = (state_q == ISSUE) && handshake && !abort && !req_last_q;

   interp_accum #(
      .WIDTH (WIDTH)
   ) u_accum (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accum_load),
      .step   (accum_step),
      .init_v (span_v0),
      .init_q (span_q0),
      .dv     (dv_q),
      .dq     (dq_q),
      .v      (req_v),
      .q      (req_q)
   );

   // Span sequencing: accept, issue beats until the last handshake or an abort, then pulse done.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         x_q         <= '0;
         dv_q        <= '0;
         dq_q        <= '0;
         req_valid_q <= 1'b0;
         req_last_q  <= 1'b0;
         span_done_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               span_done_q <= 1'b0;
               if (accept) begin
                  if (span_len != '0) begin
                     state_q     <= ISSUE;
                     remaining_q <= span_len;
                     x_q         <= span_x0;
                     dv_q        <= span_dv;
                     dq_q        <= span_dq;
                     req_valid_q <= 1'b1;
                     req_last_q  <= (span_len == LEN_W'(1));
                  end else begin
                     state_q     <= DONE;
                     span_done_q <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (abort || (handshake && req_last_q)) begin
                  state_q     <= DONE;
                  req_valid_q <= 1'b0;
                  req_last_q  <= 1'b0;
                  span_done_q <= 1'b1;
               end else if (handshake) begin
                  remaining_q <= remaining_q - LEN_W'(1);
                  x_q         <= x_q + X_W'(1);
                  req_last_q  <= (remaining_q == LEN_W'(2));
               end
            end
            DONE: begin
               state_q     <= IDLE;
               span_done_q <= 1'b0;
            end
            default: begin
               state_q     <= IDLE;
               req_valid_q <= 1'b0;
               req_last_q  <= 1'b0;
               span_done_q <= 1'b0;
            end
         endcase
      end
   end

   assign req_valid = req_valid_q;
   assign req_last  = req_last_q;
   assign req_x     = x_q;
   assign req_dv    = dv_q;
   assign req_dq    = dq_q;
   assign span_done = span_done_q;
   assign busy      = (state_q != IDLE);

endmodule
